xmii_io_rx: RTL and testbench
=============================

# xmii_io_rx

Parametrised receive-side pin driver for the PHY-to-MAC data path. It registers receive data, valid and error at each clock-enable strobe and generates the forwarded receive clock with a programmable low phase. Isolation is frame-aware and is exposed as a separate output-enable for the top-level IO cells, so the block carries no vendor primitives. It replaces the fixed 4-bit, fixed-ratio receive output stage and sits between the PCS receive path and the top-level pads.

## Interface
- DATA_W, 4, receive data width (4 = MII, 8 = GMII-style).
- LOW_CYCLES, 2, clk cycles rx_clk is held low after each data update; legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- isolate  in  1  isolation request (level).
- ce  in  1  data-update strobe, nominally one cycle every ≥ LOW_CYCLES+1 clks.
- valid  in  1  frame data valid.
- err  in  1  receive error.
- data  in  DATA_W  receive nibble/byte.
- rx_clk  out  1  forwarded receive clock.
- rx_dv  out  1  registered valid.
- rx_er  out  1  registered error.
- rxd  out  DATA_W  registered data.
- out_en  out  1  pad output enable (1 = drive, 0 = high-Z).
- ce_err  out  1  one-cycle pulse: ce arrived while rx_clk was still low.

## Operation
- Reset values: rx_clk=1, rx_dv=0, rx_er=0, rxd=0, ce_err=0, out_en=0; clock FSM in HIGH; isolation FSM in ISOLATED.
- Data path: on a clk edge with ce=1, rx_dv/rx_er/rxd <= valid/err/data; otherwise hold. Updates happen regardless of out_en.
- Clock FSM, states HIGH, LOW (with low_cnt):
  - HIGH, ce=1 -> LOW, rx_clk<=0, low_cnt<=LOW_CYCLES-1.
  - LOW, ce=0, low_cnt≠0 -> low_cnt-1; low_cnt=0 -> HIGH, rx_clk<=1.
  - LOW, ce=1 -> ce_err pulse, data still updated, low_cnt reloaded to LOW_CYCLES-1, stay LOW.
  - Net effect: rx_clk falls in the same cycle the data changes and rises LOW_CYCLES cycles later, so data is stable around the rising edge.
- Isolation FSM, states ISOLATED, ACTIVE, DRAIN:
  - ISOLATED, isolate=0 -> ACTIVE on the next ce with valid=0; out_en<=1.
  - ACTIVE, isolate=1 -> DRAIN, or per Configuration.
  - DRAIN, ce=1 with valid=0 -> ISOLATED, out_en<=0.
  - DRAIN, isolate=0 -> ACTIVE.
- Never enable mid-frame: entry to ACTIVE requires a ce with valid=0.

## Timing
- Data latency: 1 clk from ce to rxd/rx_dv/rx_er.
- rx_clk low phase is exactly LOW_CYCLES clks. The high phase lasts until the next ce, so the minimum clean period is LOW_CYCLES+1.
- ce_err is asserted in the same cycle the early ce's data is registered.
- out_en changes coincide with the rising clk edge of the qualifying ce; the data registered on that edge is valid=0.
- Simultaneous isolate rise and ce with valid=0 in ACTIVE: go straight to ISOLATED (deferred build) without a DRAIN cycle.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously).

## Configuration
- XMII_RX_FRAME_ISOLATE_EN defined: isolation entry is deferred through DRAIN as above, and frames in flight are never truncated.
- Undefined: ACTIVE with isolate=1 goes to ISOLATED on the next clk and out_en<=0 immediately. The DRAIN state is not built. Exit from isolation still waits for a ce with valid=0.

## Structure
- Shared package xmii_pkg: clock FSM state encoding, isolation FSM state encoding, and the function computing the low_cnt width ($clog2(LOW_CYCLES+1)).
- One sub-module, xmii_rx_clkgen: the clock FSM, low_cnt and ce_err. The top level holds the data registers and the isolation FSM.

## Test plan
- Reset, LOW_CYCLES=2, ce every 5 clks with data=4'hA, valid=0 -> rxd=A one clk after ce; rx_clk low 2 clks, high 3; out_en=1 after first ce; ce_err never set.
- ce every 2 clks with LOW_CYCLES=2 -> ce_err pulses on each ce after the first; rx_clk stays 0 throughout; rxd tracks every ce.
- Raise isolate at the 3rd nibble of a 10-nibble frame (macro defined) -> out_en stays 1 until the first ce with valid=0 after the frame, then 0.
- Same stimulus with the macro undefined -> out_en=0 one clk after isolate rises.
- Drop isolate while valid=1 -> out_en stays 0 until the frame ends and a ce with valid=0 occurs.
- Assert rst_n=0 mid-frame between clk edges -> rx_clk=1, rxd=0, rx_dv=0, out_en=0 immediately.

Source files
------------

// File: rtl/xmii_pkg.sv
// Shared definitions for the xMII receive pin driver: clock FSM and
// isolation FSM state encodings, plus the low-phase counter width helper.
package xmii_pkg;

    // Forwarded receive clock phase.
    typedef enum logic {
        CLK_HIGH = 1'b0,
        CLK_LOW  = 1'b1
    } clk_state_t;

    // Pad isolation state. DRAIN is only reachable when frame-aware
    // isolation (XMII_RX_FRAME_ISOLATE_EN) is compiled in.
    typedef enum logic [1:0] {
        ISO_ISOLATED = 2'd0,
        ISO_ACTIVE   = 2'd1,
        ISO_DRAIN    = 2'd2
    } iso_state_t;

    // Width of a counter that must hold values 0..low_cycles.
    function automatic int low_cnt_width(input int low_cycles);
        return $clog2(low_cycles + 1);
    endfunction

endpackage

// File: rtl/xmii_rx_clkgen.sv
// Forwarded receive clock generator. rx_clk is low while the FSM is in
// CLK_LOW: it falls on the ce that updates data and rises LOW_CYCLES clocks
// later. A ce arriving during the low phase is flagged on ce_err and restarts
// the low phase. LOW_CYCLES legal range is 1..15.
module xmii_rx_clkgen
    import xmii_pkg::*;
#(
    parameter int LOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output clk_state_t state,
    output logic       ce_err
);

    localparam int CW = low_cnt_width(LOW_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(LOW_CYCLES - 1);

    clk_state_t    state_next;
    logic [CW-1:0] low_cnt;
    logic [CW-1:0] low_cnt_next;
    logic          ce_err_next;

    // State, low-phase counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLK_HIGH;
            low_cnt <= '0;
            ce_err  <= 1'b0;
        end else begin
            state   <= state_next;
            low_cnt <= low_cnt_next;
            ce_err  <= ce_err_next;
        end
    end

    // Next-state logic: enter LOW on ce, count down, return HIGH at zero.
    always_comb begin
        state_next   = state;
        low_cnt_next = low_cnt;
        ce_err_next  = 1'b0;
        case (state)
            CLK_HIGH: begin
                if (ce) begin
                    state_next   = CLK_LOW;
                    low_cnt_next = RELOAD;
                end
            end
            CLK_LOW: begin
                if (ce) begin
                    // Early update: data still moves, low phase restarts.
                    ce_err_next  = 1'b1;
                    low_cnt_next = RELOAD;
                end else if (low_cnt != '0) begin
                    low_cnt_next = low_cnt - CW'(1);
                end else begin
                    state_next = CLK_HIGH;
                end
            end
            default: begin
                state_next = CLK_HIGH;
            end
        endcase
    end

endmodule

// File: rtl/xmii_io_rx.sv
// Receive-side pin driver for the PHY-to-MAC path. Registers data/valid/error
// on each ce strobe, forwards a receive clock, and produces a frame-aware pad
// output enable. Optional feature macro: XMII_RX_FRAME_ISOLATE_EN (defer
// isolation until the current frame has ended, via a DRAIN state).
module xmii_io_rx
    import xmii_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int LOW_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              isolate,
    input  logic              ce,
    input  logic              valid,
    input  logic              err,
    input  logic [DATA_W-1:0] data,
    output logic              rx_clk,
    output logic              rx_dv,
    output logic              rx_er,
    output logic [DATA_W-1:0] rxd,
    output logic              out_en,
    output logic              ce_err
);

    clk_state_t clk_state;
    iso_state_t iso_state;
    iso_state_t iso_next;
    logic       idle_ce;

    // A ce carrying valid=0 marks an inter-frame gap: the only safe point
    // to switch the pads on or off.
    assign idle_ce = ce & ~valid;

    // Output data registers, updated on every ce regardless of out_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dv <= 1'b0;
            rx_er <= 1'b0;
            rxd   <= '0;
        end else if (ce) begin
            rx_dv <= valid;
            rx_er <= err;
            rxd   <= data;
        end
    end

    xmii_rx_clkgen #(
        .LOW_CYCLES(LOW_CYCLES)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .state (clk_state),
        .ce_err(ce_err)
    );

    assign rx_clk = (clk_state == CLK_HIGH);

    // Isolation state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iso_state <= ISO_ISOLATED;
        end else begin
            iso_state <= iso_next;
        end
    end

    // Isolation next-state: enable only at a gap, disable per build option.
    always_comb begin
        iso_next = iso_state;
        case (iso_state)
            ISO_ISOLATED: begin
                if (!isolate && idle_ce) begin
                    iso_next = ISO_ACTIVE;
                end
            end
            ISO_ACTIVE: begin
                if (isolate) begin
`ifdef XMII_RX_FRAME_ISOLATE_EN
                    // Already at a gap: skip the DRAIN cycle.
                    iso_next = idle_ce ? ISO_ISOLATED : ISO_DRAIN;
`else
                    iso_next = ISO_ISOLATED;
`endif
                end
            end
`ifdef XMII_RX_FRAME_ISOLATE_EN
            ISO_DRAIN: begin
                if (!isolate) begin
                    iso_next = ISO_ACTIVE;
                end else if (idle_ce) begin
                    iso_next = ISO_ISOLATED;
                end
            end
`endif
            default: begin
                iso_next = ISO_ISOLATED;
            end
        endcase
    end

    // Pads drive in ACTIVE and while draining the frame in flight.
    assign out_en = (iso_state != ISO_ISOLATED);

endmodule

// File: tb/tb_xmii_io_rx.sv
`timescale 1ns/1ps
module tb_xmii_io_rx;

    localparam int DATA_W = 4;
    localparam int L      = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              isolate = 1'b0;
    logic              ce = 1'b0;
    logic              valid = 1'b0;
    logic              err = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              rx_clk;
    logic              rx_dv;
    logic              rx_er;
    logic [DATA_W-1:0] rxd;
    logic              out_en;
    logic              ce_err;

    always #5 clk = ~clk;

    xmii_io_rx #(
        .DATA_W(DATA_W),
        .LOW_CYCLES(L)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .isolate(isolate),
        .ce     (ce),
        .valid  (valid),
        .err    (err),
        .data   (data),
        .rx_clk (rx_clk),
        .rx_dv  (rx_dv),
        .rx_er  (rx_er),
        .rxd    (rxd),
        .out_en (out_en),
        .ce_err (ce_err)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic              rx_clk;
        logic              rx_dv;
        logic              rx_er;
        logic [DATA_W-1:0] rxd;
        logic              out_en;
        logic              ce_err;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned tag_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // rx_clk is low for L edges after the most recent ce; a ce that lands
    // within L edges of the previous one is an early update. Pads are on
    // from a gap ce while not isolating until the isolation point.
    bit                have_ce;
    int unsigned       last_ce;
    bit                m_en;
    logic              m_dv;
    logic              m_er;
    logic [DATA_W-1:0] m_d;

    task automatic reset_model();
        have_ce = 1'b0;
        last_ce = 0;
        m_en    = 1'b0;
        m_dv    = 1'b0;
        m_er    = 1'b0;
        m_d     = '0;
    endtask

    // Drive one cycle of inputs, push the outputs expected after the edge.
    task automatic drive(input logic i_ce, input logic i_valid, input logic i_err,
                         input logic [DATA_W-1:0] i_data, input logic i_iso);
        int unsigned e;
        obs_t        x;
        ce      = i_ce;
        valid   = i_valid;
        err     = i_err;
        data    = i_data;
        isolate = i_iso;
        e = cyc + 1;
        x.ce_err = i_ce && have_ce && ((e - last_ce) <= L);
        if (i_ce) begin
            have_ce = 1'b1;
            last_ce = e;
            m_dv    = i_valid;
            m_er    = i_err;
            m_d     = i_data;
        end
        x.rx_clk = !have_ce || ((e - last_ce) >= L);
        if (m_en) begin
`ifdef XMII_RX_FRAME_ISOLATE_EN
            if (i_iso && i_ce && !i_valid) m_en = 1'b0;
`else
            if (i_iso) m_en = 1'b0;
`endif
        end else if (!i_iso && i_ce && !i_valid) begin
            m_en = 1'b1;
        end
        x.rx_dv  = m_dv;
        x.rx_er  = m_er;
        x.rxd    = m_d;
        x.out_en = m_en;
        exp_q.push_back(x);
        tag_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic iso);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  DATA_W'($urandom), iso);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rx_clk"}, 32'(rx_clk), 32'd1);
        check({tag, ".rx_dv"},  32'(rx_dv),  32'd0);
        check({tag, ".rx_er"},  32'(rx_er),  32'd0);
        check({tag, ".rxd"},    32'(rxd),    32'd0);
        check({tag, ".out_en"}, 32'(out_en), 32'd0);
        check({tag, ".ce_err"}, 32'(ce_err), 32'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            while (tag_q.size() > 0 && tag_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cyc, tag_q[0]);
                void'(tag_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (tag_q.size() > 0 && tag_q[0] == cyc) begin
                obs_t x;
                x = exp_q.pop_front();
                void'(tag_q.pop_front());
                check("rx_clk", 32'(rx_clk), 32'(x.rx_clk));
                check("rx_dv",  32'(rx_dv),  32'(x.rx_dv));
                check("rx_er",  32'(rx_er),  32'(x.rx_er));
                check("rxd",    32'(rxd),    32'(x.rxd));
                check("out_en", 32'(out_en), 32'(x.out_en));
                check("ce_err", 32'(ce_err), 32'(x.ce_err));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic iso_r;
        reset_model();
        repeat (3) @(posedge clk);
        check_reset_values("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("after_reset");
        @(posedge clk);
        #1;

        // Clean rate: ce every 5 clocks, gap data 0xA.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'hA, 1'b0);
            idle(4, 1'b0);
        end

        // Too-fast rate: ce every 2 clocks, early-update errors.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0);
            idle(1, 1'b0);
        end
        idle(3, 1'b0);

        // Isolation raised on the 3rd nibble of a 10-nibble frame.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        idle(2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            iso_r = (k >= 2);
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), DATA_W'($urandom), iso_r);
            idle(2, iso_r);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom), 1'b1);
            idle(2, 1'b1);
        end

        // Isolation dropped mid-frame: pads wait for the next gap.
        for (int k = 0; k < 8; k++) begin
            iso_r = (k < 3);
            drive(1'b1, 1'b1, 1'b0, DATA_W'($urandom), iso_r);
            idle(2, iso_r);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom), 1'b0);
            idle(2, 1'b0);
        end

        // Random traffic with occasional isolation toggles.
        iso_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) iso_r = ~iso_r;
            drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0), DATA_W'($urandom), iso_r);
        end

        // Mid-frame asynchronous reset while rx_clk is low.
        drive(1'b1, 1'b0, 1'b0, 4'h3, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
        idle(1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
        ce = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Resume after reset.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, DATA_W'($urandom), 1'b0);
            idle(2, 1'b0);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (tag_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", tag_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
